// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
//   Bundles the field-input handshake, the encoded-output handshake and the
//   statistics counters of instr_encoder into one interface.
//
//   Field side   : in_valid_i / in_ready_o handshake carrying opcode_i, rd_i,
//                  rs1_i, rs2_i, funct3_i, funct7_i and imm_i (32-bit,
//                  sign-extended as an immediate generator would produce it).
//   Output side  : out_valid_o / out_ready_i handshake carrying insn_o
//                  (encoded RV32I word) and err_o (entry failed encoding).
//   Statistics   : enc_count_o (accepted bundles, wrapping 16 bits) and
//                  err_count_o (accepted error bundles, saturating at 255).
//
//   slave  : the encoder itself
//   master : whoever builds the field bundles and consumes the words
// ----------------------------------------------------------------------------
interface instr_encoder_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [6:0]  opcode_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] insn_o;
    logic        err_o;
    logic [15:0] enc_count_o;
    logic [7:0]  err_count_o;

    modport slave (
        input  in_valid_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o, insn_o, err_o, enc_count_o, err_count_o
    );

    modport master (
        output in_valid_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o, insn_o, err_o, enc_count_o, err_count_o
    );
endinterface

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Inverse of the immediate generator: packs decoded fields into an RV32I
//   instruction word, scattering the immediate bits according to the format
//   selected by the opcode (R/I/S/B/U/J) and range-checking the immediate.
//   Encoded words (or error markers) are queued in a small output FIFO so the
//   producer and consumer are decoupled by a valid/ready handshake each side.
//
// Parameters
//   DEPTH        output FIFO entries (power of 2, >= 2)
//   CHECK_RANGE  1: out-of-range / misaligned immediates produce an error
//                0: immediates are truncated silently (bad opcodes still err)
//
// Ports
//   clk    clock
//   reset  synchronous, active-high; empties the FIFO and clears counters
//   bus    instr_encoder_if.slave (field input, word output, counters)
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH       = 2,
    parameter int CHECK_RANGE = 1
) (
    input  logic            clk,
    input  logic            reset,
    instr_encoder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0] imm;
    logic [31:0] encInsn;
    logic        rangeErr;
    logic        badOp;
    logic        encErr;
    logic [31:0] pushInsn;
    logic        fits12;
    logic        fits13;
    logic        fits21;

    logic [31:0]   memInsn [DEPTH];
    logic          memErr  [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;
    logic [CW-1:0] remaining;
    logic          inReady;
    logic [31:0]   headInsn;
    logic          headErr;
    logic [15:0]   encCount;
    logic [7:0]    errCount;
    logic          push;
    logic          pop;

    assign imm = bus.imm_i;

    // An immediate fits an N-bit signed field when every bit from N-1 upward
    // is a copy of the sign, i.e. the top bits are all ones or all zeros.
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    // Format-dependent bit scattering. Fields the format does not use are
    // simply not looked at. Shift-immediates reuse the I layout but take
    // funct7 in the top bits and a 5-bit unsigned shift amount.
    always_comb begin
        encInsn  = 32'd0;
        rangeErr = 1'b0;
        badOp    = 1'b0;
        case (bus.opcode_i)
            OP_R: begin
                encInsn = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, bus.opcode_i};
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                if (bus.opcode_i == OP_IMM && (bus.funct3_i == 3'b001 || bus.funct3_i == 3'b101)) begin
                    encInsn  = {bus.funct7_i, imm[4:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.opcode_i};
                    rangeErr = |imm[31:5];
                end else begin
                    encInsn  = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.opcode_i};
                    rangeErr = ~fits12;
                end
            end
            OP_STORE: begin
                encInsn  = {imm[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:0], bus.opcode_i};
                rangeErr = ~fits12;
            end
            OP_BRANCH: begin
                encInsn  = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                            imm[4:1], imm[11], bus.opcode_i};
                rangeErr = ~fits13 | imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                encInsn  = {imm[31:12], bus.rd_i, bus.opcode_i};
                rangeErr = |imm[11:0];
            end
            OP_JAL: begin
                encInsn  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd_i, bus.opcode_i};
                rangeErr = ~fits21 | imm[0];
            end
            default: begin
                badOp = 1'b1;
            end
        endcase
    end

    // A bad opcode always errs; a bad immediate only when checking is on.
    // Error entries carry an all-zero word so consumers never see garbage.
    assign encErr   = badOp | ((CHECK_RANGE != 0) & rangeErr);
    assign pushInsn = encErr ? 32'd0 : encInsn;

    assign push      = bus.in_valid_i & inReady;
    assign pop       = (count != '0) & bus.out_ready_i;
    assign countNext = count + CW'(push) - CW'(pop);
    assign remaining = count - CW'(pop);

    // FIFO storage needs no reset: the occupancy count decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            memInsn[wptr] <= pushInsn;
            memErr[wptr]  <= encErr;
        end
    end

    // Pointers, occupancy, registered ready and the output head registers.
    // The head is reloaded whenever it is popped so the outputs always show
    // the oldest live entry; if the FIFO drains, the last word stays visible.
    // A push into an empty (or just-emptied) FIFO lands in the head directly,
    // giving one cycle of latency without a same-cycle bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            inReady  <= 1'b1;
            headInsn <= 32'd0;
            headErr  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            count   <= countNext;
            inReady <= (countNext < CW'(DEPTH));
            if (remaining != '0) begin
                headInsn <= memInsn[rptr + AW'(pop)];
                headErr  <= memErr[rptr + AW'(pop)];
            end else if (push) begin
                headInsn <= pushInsn;
                headErr  <= encErr;
            end
        end
    end

    // Statistics: every accepted bundle counts (wrapping), error bundles are
    // counted separately and stick at the top of the 8-bit range.
    always_ff @(posedge clk) begin
        if (reset) begin
            encCount <= 16'd0;
            errCount <= 8'd0;
        end else if (push) begin
            encCount <= encCount + 16'd1;
            if (encErr && errCount != 8'hFF) begin
                errCount <= errCount + 8'd1;
            end
        end
    end

    assign bus.in_ready_o  = inReady;
    assign bus.out_valid_o = (count != '0);
    assign bus.insn_o      = headInsn;
    assign bus.err_o       = headErr;
    assign bus.enc_count_o = encCount;
    assign bus.err_count_o = errCount;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//   Drives two encoders (range checking on and off) with identical field
//   bundles. Expected words are queued when a bundle is accepted and compared
//   when each encoder presents an output that is being consumed.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

    typedef struct {
        logic [31:0] insn;
        logic        err;
    } expT;

    logic clk = 1'b0;
    logic reset = 1'b1;

    instr_encoder_if busA ();
    instr_encoder_if busB ();

    instr_encoder #(.DEPTH(2), .CHECK_RANGE(1)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA.slave)
    );

    instr_encoder #(.DEPTH(2), .CHECK_RANGE(0)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB.slave)
    );

    expT qA[$];
    expT qB[$];
    int compared = 0;
    int mismatched = 0;
    logic [15:0] modelAccepts = 16'd0;
    logic [7:0]  modelErrsA = 8'd0;
    logic [7:0]  modelErrsB = 8'd0;

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Present a bundle to both encoders, wait (bounded) for acceptance and
    // queue the expected result for each at the accepting edge.
    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm, input logic [31:0] insnA, input logic errA,
                                 input logic [31:0] insnB, input logic errB);
        int waited = 0;
        bit done = 0;
        expT e;
        busA.opcode_i = op;  busB.opcode_i = op;
        busA.rd_i = rd;      busB.rd_i = rd;
        busA.rs1_i = rs1;    busB.rs1_i = rs1;
        busA.rs2_i = rs2;    busB.rs2_i = rs2;
        busA.funct3_i = f3;  busB.funct3_i = f3;
        busA.funct7_i = f7;  busB.funct7_i = f7;
        busA.imm_i = imm;    busB.imm_i = imm;
        busA.in_valid_i = 1'b1;
        busB.in_valid_i = 1'b1;
        while (!done && waited < 50) begin
            @(negedge clk);
            if (busA.in_ready_o) begin
                e.insn = insnA; e.err = errA; qA.push_back(e);
                e.insn = insnB; e.err = errB; qB.push_back(e);
                modelAccepts = modelAccepts + 16'd1;
                if (errA && modelErrsA != 8'hFF) modelErrsA = modelErrsA + 8'd1;
                if (errB && modelErrsB != 8'hFF) modelErrsB = modelErrsB + 8'd1;
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                waited++;
            end
        end
        busA.in_valid_i = 1'b0;
        busB.in_valid_i = 1'b0;
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic setOutReady(input logic r);
        busA.out_ready_i = r;
        busB.out_ready_i = r;
    endtask

    // Bounded wait until every queued expectation has been matched.
    task automatic waitDrain();
        int n = 0;
        while ((qA.size() != 0 || qB.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) checkOutput("drain_timeout", 32'(qA.size() + qB.size()), 32'd0);
        #1;
    endtask

    // Output monitors: a consumed head must match the oldest expectation.
    always @(negedge clk) begin
        expT e;
        if (!reset && busA.out_valid_o && busA.out_ready_i) begin
            if (qA.size() == 0) begin
                checkOutput("A_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = qA.pop_front();
                checkOutput("A_insn", busA.insn_o, e.insn);
                checkOutput("A_err", 32'(busA.err_o), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        expT e;
        if (!reset && busB.out_valid_o && busB.out_ready_i) begin
            if (qB.size() == 0) begin
                checkOutput("B_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = qB.pop_front();
                checkOutput("B_insn", busB.insn_o, e.insn);
                checkOutput("B_err", 32'(busB.err_o), 32'(e.err));
            end
        end
    end

    initial begin
        busA.in_valid_i = 1'b0; busB.in_valid_i = 1'b0;
        busA.opcode_i = '0; busB.opcode_i = '0;
        busA.rd_i = '0; busB.rd_i = '0;
        busA.rs1_i = '0; busB.rs1_i = '0;
        busA.rs2_i = '0; busB.rs2_i = '0;
        busA.funct3_i = '0; busB.funct3_i = '0;
        busA.funct7_i = '0; busB.funct7_i = '0;
        busA.imm_i = '0; busB.imm_i = '0;
        setOutReady(1'b0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("reset_out_valid", 32'(busA.out_valid_o), 32'd0);
        checkOutput("reset_in_ready", 32'(busA.in_ready_o), 32'd1);
        checkOutput("reset_insn", busA.insn_o, 32'd0);
        checkOutput("reset_err", 32'(busA.err_o), 32'd0);
        checkOutput("reset_enc_count", 32'(busA.enc_count_o), 32'd0);
        checkOutput("reset_err_count", 32'(busA.err_count_o), 32'd0);

        @(posedge clk); #1;
        setOutReady(1'b1);

        $display("[TB] addi and one-cycle latency");
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h00500093, 0, 32'h00500093, 0);
        @(negedge clk);
        checkOutput("latency_out_valid", 32'(busA.out_valid_o), 32'd1);
        waitDrain();

        $display("[TB] sw then lui back to back");
        applyStimulus(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020A423, 0, 32'h0020A423, 0);
        applyStimulus(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123452B7, 0, 32'h123452B7, 0);
        @(negedge clk);
        checkOutput("b2b_second_valid", 32'(busA.out_valid_o), 32'd1);
        waitDrain();

        $display("[TB] jal and misaligned beq");
        applyStimulus(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFFFFC, 32'hFFDFF0EF, 0, 32'hFFDFF0EF, 0);
        applyStimulus(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, 32'd0, 1, 32'h00000163, 0);
        waitDrain();
        checkOutput("A_err_count_after_beq", 32'(busA.err_count_o), 32'd1);
        checkOutput("B_err_count_after_beq", 32'(busB.err_count_o), 32'd0);

        $display("[TB] format boundaries");
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFF800, 32'h80000093, 0, 32'h80000093, 0);
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 32'd0, 1, 32'h80000093, 0);
        applyStimulus(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd31, 32'h01F09093, 0, 32'h01F09093, 0);
        applyStimulus(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd32, 32'd0, 1, 32'h00009093, 0);
        applyStimulus(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b101, 7'b0100000, 32'd4, 32'h4040D093, 0, 32'h4040D093, 0);
        applyStimulus(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFF000, 32'h80000063, 0, 32'h80000063, 0);
        applyStimulus(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096, 32'd0, 1, 32'h80000063, 0);
        applyStimulus(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345001, 32'd0, 1, 32'h123452B7, 0);
        applyStimulus(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'hDEADBEEF, 32'h002081B3, 0, 32'h002081B3, 0);
        applyStimulus(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'b0100000, 32'd0, 32'h402081B3, 0, 32'h402081B3, 0);
        applyStimulus(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00100000, 32'd0, 1, 32'h800000EF, 0);
        waitDrain();

        $display("[TB] backpressure with a full FIFO");
        setOutReady(1'b0);
        applyStimulus(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 32'h00100113, 0, 32'h00100113, 0);
        applyStimulus(7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2, 32'h00200193, 0, 32'h00200193, 0);
        fork
            applyStimulus(7'b0010011, 5'd4, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, 32'h00300213, 0, 32'h00300213, 0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", 32'(busA.in_ready_o), 32'd0);
                    checkOutput("stall_out_valid", 32'(busA.out_valid_o), 32'd1);
                    checkOutput("stall_head_stable", busA.insn_o, 32'h00100113);
                end
                @(posedge clk); #1;
                setOutReady(1'b1);
            end
        join
        waitDrain();

        $display("[TB] bad opcode and truncation");
        applyStimulus(7'b1111111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 32'd0, 1, 32'd0, 1);
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096, 32'd0, 1, 32'h00000093, 0);
        waitDrain();
        checkOutput("A_enc_count", 32'(busA.enc_count_o), 32'(modelAccepts));
        checkOutput("A_err_count", 32'(busA.err_count_o), 32'(modelErrsA));
        checkOutput("B_err_count", 32'(busB.err_count_o), 32'(modelErrsB));

        $display("[TB] error counter saturation");
        for (int i = 0; i < 260; i++) begin
            applyStimulus(7'b1111111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 32'd0, 1, 32'd0, 1);
        end
        waitDrain();
        checkOutput("A_err_count_sat", 32'(busA.err_count_o), 32'd255);
        checkOutput("B_err_count_sat", 32'(busB.err_count_o), 32'd255);
        checkOutput("A_enc_count_after_sat", 32'(busA.enc_count_o), 32'(modelAccepts));

        $display("[TB] reset with entries buffered");
        setOutReady(1'b0);
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h00500093, 0, 32'h00500093, 0);
        applyStimulus(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 32'h00100113, 0, 32'h00100113, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        qA.delete();
        qB.delete();
        modelAccepts = 16'd0;
        modelErrsA = 8'd0;
        modelErrsB = 8'd0;
        @(negedge clk);
        checkOutput("midreset_out_valid", 32'(busA.out_valid_o), 32'd0);
        checkOutput("midreset_in_ready", 32'(busA.in_ready_o), 32'd1);
        checkOutput("midreset_enc_count", 32'(busA.enc_count_o), 32'd0);
        checkOutput("midreset_err_count", 32'(busA.err_count_o), 32'd0);
        checkOutput("midreset_B_out_valid", 32'(busB.out_valid_o), 32'd0);
        @(posedge clk); #1;
        setOutReady(1'b1);
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h00500093, 0, 32'h00500093, 0);
        waitDrain();
        checkOutput("post_reset_enc_count", 32'(busA.enc_count_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
